hilo_unit: RTL

HILO_UNIT -- requirements
Module: hilo_unit

---
 rtl/hilo_unit_pkg.sv | 23 ++
 rtl/div_core.sv | 80 ++++++++
 rtl/hilo_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM states, ALU
// control codes and divider constants.
package hilo_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    FIX  = 2'd2
  } state_e;

  localparam logic [4:0] ALU_AND  = 5'd0;
  localparam logic [4:0] ALU_OR   = 5'd1;
  localparam logic [4:0] ALU_ADD  = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SLT  = 5'd4;
  localparam logic [4:0] ALU_MUL  = 5'd5;
  localparam logic [4:0] ALU_DIV  = 5'd6;
  localparam logic [4:0] ALU_DIVU = 5'd7;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] DIV0_LO   = 32'hFFFF_FFFF;

endpackage

// File: rtl/div_core.sv
// Restoring divider datapath: one quotient bit per step on operand magnitudes,
// with sign fix-up and the divide-by-zero result applied on the outputs.
module div_core
  import hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_step,
  input  logic             i_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_last,
  output logic [WIDTH-1:0] o_quo,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_dz
);

  localparam int unsigned CntW = $clog2(DIV_ITERS);

  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_dz;

  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;

  assign w_a_neg  = i_signed & i_a[WIDTH-1];
  assign w_b_neg  = i_signed & i_b[WIDTH-1];
  assign w_b_zero = (i_b == '0);
  assign w_a_mag  = w_a_neg ? -i_a : i_a;
  assign w_b_mag  = w_b_neg ? -i_b : i_b;

  // Bring in the next dividend bit; the borrow out of bit WIDTH means "too small".
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_dvs   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= '0;
      r_rem   <= w_b_zero ? i_a : '0;
      r_quo   <= w_b_zero ? WIDTH'(DIV0_LO) : w_a_mag;
      r_dvs   <= w_b_mag;
      r_neg_q <= w_a_neg ^ w_b_neg;
      r_neg_r <= w_a_neg;
      r_dz    <= w_b_zero;
    end else if (i_step) begin
      r_cnt <= r_cnt + 1'b1;
      r_rem <= w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      r_quo <= {r_quo[WIDTH-2:0], w_ge};
    end
  end

  assign o_last = (r_cnt == CntW'(DIV_ITERS - 1));
  assign o_quo  = (r_neg_q && !r_dz) ? -r_quo : r_quo;
  assign o_rem  = (r_neg_r && !r_dz) ? -r_rem : r_rem;
  assign o_dz   = r_dz;

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register unit: accepts MUL results, move-to writes and iterative
// DIV/DIVU operations, writing the division result back in the FIX state.
module hilo_unit
  import hilo_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mul_valid,
  input  logic [WIDTH-1:0] mul_lo,
  input  logic [WIDTH-1:0] mul_hi,
  input  logic             div_start,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             div_done,
  output logic             div_by_zero
);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_done;
  logic             r_dz;

  logic             w_idle;
  logic             w_div_acc;
  logic             w_mul_acc;
  logic             w_mt_acc;
  logic             w_step;
  logic             w_fix_wr;
  logic             w_last;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_dz;

  assign w_idle    = (r_state == IDLE);
  assign w_div_acc = w_idle & div_start;
  assign w_mul_acc = w_idle & ~div_start & mul_valid;
  assign w_mt_acc  = w_idle & ~div_start & ~mul_valid;
  assign w_step    = (r_state == DIV) & ~flush;
  assign w_fix_wr  = (r_state == FIX) & ~flush;

  div_core #(
    .WIDTH (WIDTH)
  ) u_div_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_div_acc),
    .i_step   (w_step),
    .i_signed (div_signed),
    .i_a      (op_a),
    .i_b      (op_b),
    .o_last   (w_last),
    .o_quo    (w_quo),
    .o_rem    (w_rem),
    .o_dz     (w_dz)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (div_start) w_state_next = (op_b == '0) ? FIX : DIV;
      DIV:     if (w_last) w_state_next = FIX;
      FIX:     w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
    // Flush in IDLE must not block a same-cycle request.
    if (flush && !w_idle) w_state_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_fix_wr;
      r_dz    <= w_fix_wr & w_dz;
      if (w_fix_wr) begin
        r_hi <= w_rem;
        r_lo <= w_quo;
      end else if (w_mul_acc) begin
        r_hi <= mul_hi;
        r_lo <= mul_lo;
      end else if (w_mt_acc) begin
        if (mthi) r_hi <= wdata;
        if (mtlo) r_lo <= wdata;
      end
    end
  end

  assign hi          = r_hi;
  assign lo          = r_lo;
  assign busy        = ~w_idle;
  assign div_done    = r_done;
  assign div_by_zero = r_dz;

endmodule
